fetch_decode_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage, replacing the plain F/D pipeline register. It captures each fetched instruction with its PC and PC+4 into a small ring buffer and drives the decode-stage register from the buffer head. Decode stalls therefore do not immediately stall fetch; fetch stalls only when the queue is full. A taken branch (flush) empties the queue and injects a bubble.

---
 rtl/fdq_pkg.sv | 16 +
 rtl/fetch_decode_queue_if.sv | 30 +++
 rtl/fdq_ring.sv | 60 ++++++
 rtl/fetch_decode_queue.sv | 81 ++++++++
 tb/tb_fetch_decode_queue.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fdq_pkg.sv
// Shared types for the fetch/decode instruction queue: entry layout and the bubble.
// No logic; a bubble is an ADDI x0,x0,0 with zero PCs and is never marked valid.
// No backpressure.
package fdq_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fdq_entry_t;

    localparam fdq_entry_t FDQ_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side push bus and decode-stage register outputs of the instruction queue.
// Pure wiring, zero latency.
// Fetch is held off through o_ReadyF; decode holds through i_StallD.
interface fetch_decode_queue_if #(
    parameter int DEPTH = 4
);
    logic                         i_ValidF;
    logic [31:0]                  i_InstrF;
    logic [31:0]                  i_PCF;
    logic [31:0]                  i_PCPlus4F;
    logic                         o_ReadyF;
    logic                         i_StallD;
    logic                         i_FlushD;
    logic [31:0]                  o_InstrD;
    logic [31:0]                  o_PCD;
    logic [31:0]                  o_PCPlus4D;
    logic                         o_ValidD;
    logic [$clog2(DEPTH+1)-1:0]   o_Count;

    modport master (
        output i_ValidF, i_InstrF, i_PCF, i_PCPlus4F, i_StallD, i_FlushD,
        input  o_ReadyF, o_InstrD, o_PCD, o_PCPlus4D, o_ValidD, o_Count
    );

    modport slave (
        input  i_ValidF, i_InstrF, i_PCF, i_PCPlus4F, i_StallD, i_FlushD,
        output o_ReadyF, o_InstrD, o_PCD, o_PCPlus4D, o_ValidD, o_Count
    );

endinterface

// File: rtl/fdq_ring.sv
// Generic ring FIFO of fdq entries with push/pop/clear, wrapping pointers and a count.
// Head entry is visible combinationally; a push becomes head one edge later.
// rdy is low only when full and depends on registered state alone.
module fdq_ring
    import fdq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  fdq_entry_t      push_dat,
    input  logic            pop,
    output fdq_entry_t      head_dat,
    output logic [CW-1:0]   count,
    output logic            rdy
);
    localparam int PW = $clog2(DEPTH);

    fdq_entry_t        mem [DEPTH];
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     wptr;

    assign head_dat = mem[rptr];
    assign rdy      = (count != CW'(DEPTH));

    // Storage needs no reset: count gates every read of stale data.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue driving the D register; FDQ_BYPASS_EN adds empty-queue bypass.
// Latency 1 cycle with bypass on an empty queue, otherwise 2 (ring write, then head to D).
// Fetch stalls only when the ring is full; flush empties it and loads a bubble.
module fetch_decode_queue
    import fdq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    fetch_decode_queue_if.slave   q
);
    localparam int CW = $clog2(DEPTH + 1);

    fdq_entry_t       fetch_entry;
    fdq_entry_t       head_entry;
    fdq_entry_t       d_reg;
    logic             d_vld;
    logic [CW-1:0]    count;
    logic             ring_rdy;
    logic             push;
    logic             pop;
    logic             bypass;

    assign fetch_entry = '{instr: q.i_InstrF, pc: q.i_PCF, pc_plus4: q.i_PCPlus4F};

    assign pop = !q.i_FlushD && !q.i_StallD && (count != '0);

`ifdef FDQ_BYPASS_EN
    // Only taken when nothing is buffered, so it can never overtake an older entry.
    assign bypass = !q.i_FlushD && !q.i_StallD && (count == '0) && q.i_ValidF;
`else
    assign bypass = 1'b0;
`endif

    assign push = q.i_ValidF && ring_rdy && !q.i_FlushD && !bypass;

    fdq_ring #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ring (
        .clk      (i_Clk),
        .rst      (i_Reset),
        .clear    (q.i_FlushD),
        .push     (push),
        .push_dat (fetch_entry),
        .pop      (pop),
        .head_dat (head_entry),
        .count    (count),
        .rdy      (ring_rdy)
    );

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            d_reg <= FDQ_BUBBLE;
            d_vld <= 1'b0;
        end else if (q.i_FlushD) begin
            d_reg <= FDQ_BUBBLE;
            d_vld <= 1'b0;
        end else if (!q.i_StallD) begin
            if (pop) begin
                d_reg <= head_entry;
                d_vld <= 1'b1;
            end else if (bypass) begin
                d_reg <= fetch_entry;
                d_vld <= 1'b1;
            end else begin
                d_reg <= FDQ_BUBBLE;
                d_vld <= 1'b0;
            end
        end
    end

    assign q.o_ReadyF   = ring_rdy;
    assign q.o_InstrD   = d_reg.instr;
    assign q.o_PCD      = d_reg.pc;
    assign q.o_PCPlus4D = d_reg.pc_plus4;
    assign q.o_ValidD   = d_vld;
    assign q.o_Count    = count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: expected decode entries are queued at issue and
// a negedge monitor compares every instruction decode consumes; FDQ_BYPASS_EN selects latency.
module tb_fetch_decode_queue;
    import fdq_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_decode_queue_if #(.DEPTH(DEPTH)) vif ();

    fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .q       (vif)
    );

    int         n_total = 0;
    int         n_pass  = 0;
    fdq_entry_t exp_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endfunction

    function automatic logic [31:0] mk_instr(logic [31:0] pc);
        return {pc[11:0], 20'h00093};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc, input bit record);
        vif.i_ValidF   = 1'b1;
        vif.i_InstrF   = instr;
        vif.i_PCF      = pc;
        vif.i_PCPlus4F = pc + 32'd4;
        if (record) exp_q.push_back('{instr: instr, pc: pc, pc_plus4: pc + 32'd4});
    endtask

    task automatic idle();
        vif.i_ValidF = 1'b0;
    endtask

    // Decode consumes the D register at the next edge when it is valid and neither stalled nor flushed.
    always @(negedge clk) begin
        fdq_entry_t e;
        if (!rst && vif.o_ValidD && !vif.i_StallD && !vif.i_FlushD) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL decode_unexpected: got pc %h, want no instruction", vif.o_PCD);
            end else begin
                e = exp_q.pop_front();
                check("decode_instr", vif.o_InstrD, e.instr);
                check("decode_pc", vif.o_PCD, e.pc);
                check("decode_pc4", vif.o_PCPlus4D, e.pc_plus4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        vif.i_ValidF   = 1'b0;
        vif.i_InstrF   = '0;
        vif.i_PCF      = '0;
        vif.i_PCPlus4F = '0;
        vif.i_StallD   = 1'b0;
        vif.i_FlushD   = 1'b0;

        #12;
        check("rst_validd", 32'(vif.o_ValidD), 32'd0);
        check("rst_instrd", vif.o_InstrD, 32'h00000013);
        check("rst_pcd", vif.o_PCD, 32'd0);
        check("rst_pc4d", vif.o_PCPlus4D, 32'd0);
        check("rst_count", 32'(vif.o_Count), 32'd0);
        check("rst_readyf", 32'(vif.o_ReadyF), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Single instruction latency
        present(32'h00500093, 32'h0, 1'b1);
        tick();
        idle();
`ifdef FDQ_BYPASS_EN
        check("lat_validd", 32'(vif.o_ValidD), 32'd1);
        check("lat_instrd", vif.o_InstrD, 32'h00500093);
        check("lat_pcd", vif.o_PCD, 32'h0);
        check("lat_pc4d", vif.o_PCPlus4D, 32'h4);
        check("lat_count", 32'(vif.o_Count), 32'd0);
`else
        check("lat1_validd", 32'(vif.o_ValidD), 32'd0);
        check("lat1_count", 32'(vif.o_Count), 32'd1);
        tick();
        check("lat_validd", 32'(vif.o_ValidD), 32'd1);
        check("lat_instrd", vif.o_InstrD, 32'h00500093);
        check("lat_pcd", vif.o_PCD, 32'h0);
        check("lat_pc4d", vif.o_PCPlus4D, 32'h4);
        check("lat_count", 32'(vif.o_Count), 32'd0);
`endif
        tick();
        check("lat_bubble", 32'(vif.o_ValidD), 32'd0);

        // Fill to full under stall, fifth instruction held, then drain in order
        vif.i_StallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(mk_instr(32'(4 * i)), 32'(4 * i), 1'b1);
            tick();
            check("fill_count", 32'(vif.o_Count), 32'(i + 1));
        end
        check("full_readyf", 32'(vif.o_ReadyF), 32'd0);
        present(mk_instr(32'h10), 32'h10, 1'b1);
        tick();
        tick();
        check("held_count", 32'(vif.o_Count), 32'd4);
        check("held_readyf", 32'(vif.o_ReadyF), 32'd0);
        vif.i_StallD = 1'b0;
        tick();
        check("drain0_validd", 32'(vif.o_ValidD), 32'd1);
        check("drain0_pcd", vif.o_PCD, 32'h0);
        check("drain0_count", 32'(vif.o_Count), 32'd3);
        check("drain0_readyf", 32'(vif.o_ReadyF), 32'd1);
        tick();
        idle();
        check("drain1_pcd", vif.o_PCD, 32'h4);
        check("drain1_count", 32'(vif.o_Count), 32'd3);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("drain_pcd", vif.o_PCD, 32'(4 * k));
            check("drain_count", 32'(vif.o_Count), 32'(4 - k));
        end
        tick();
        check("drain_bubble", 32'(vif.o_ValidD), 32'd0);

        // Flush with two buffered entries and a simultaneous fetch
        vif.i_StallD = 1'b1;
        present(mk_instr(32'h100), 32'h100, 1'b1);
        tick();
        present(mk_instr(32'h104), 32'h104, 1'b1);
        tick();
        check("preflush_count", 32'(vif.o_Count), 32'd2);
        present(mk_instr(32'h108), 32'h108, 1'b0);
        vif.i_FlushD = 1'b1;
        exp_q.delete();
        tick();
        vif.i_FlushD = 1'b0;
        idle();
        check("flush_count", 32'(vif.o_Count), 32'd0);
        check("flush_validd", 32'(vif.o_ValidD), 32'd0);
        check("flush_instrd", vif.o_InstrD, 32'h00000013);
        check("flush_pcd", vif.o_PCD, 32'd0);
        check("flush_readyf", 32'(vif.o_ReadyF), 32'd1);
        vif.i_StallD = 1'b0;
        tick();
        tick();
        check("postflush_validd", 32'(vif.o_ValidD), 32'd0);
        check("postflush_count", 32'(vif.o_Count), 32'd0);

        // Push and pop together at DEPTH-1 across pointer wrap
        vif.i_StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(mk_instr(32'h200 + 32'(4 * i)), 32'h200 + 32'(4 * i), 1'b1);
            tick();
        end
        check("wrap_pre_count", 32'(vif.o_Count), 32'd3);
        vif.i_StallD = 1'b0;
        for (int k = 0; k < 8; k++) begin
            present(mk_instr(32'h20C + 32'(4 * k)), 32'h20C + 32'(4 * k), 1'b1);
            tick();
            check("wrap_count", 32'(vif.o_Count), 32'd3);
            check("wrap_readyf", 32'(vif.o_ReadyF), 32'd1);
            check("wrap_pcd", vif.o_PCD, 32'h200 + 32'(4 * k));
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wrap_tail_pcd", vif.o_PCD, 32'h220 + 32'(4 * k));
        end
        tick();
        check("wrap_empty_count", 32'(vif.o_Count), 32'd0);
        check("wrap_empty_validd", 32'(vif.o_ValidD), 32'd0);

        // Asynchronous reset mid-cycle with three entries and a valid D register
        vif.i_StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(mk_instr(32'h300 + 32'(4 * i)), 32'h300 + 32'(4 * i), 1'b1);
            tick();
        end
        vif.i_StallD = 1'b0;
        present(mk_instr(32'h30C), 32'h30C, 1'b1);
        tick();
        vif.i_StallD = 1'b1;
        idle();
        check("prerst_count", 32'(vif.o_Count), 32'd3);
        check("prerst_validd", 32'(vif.o_ValidD), 32'd1);
        check("prerst_pcd", vif.o_PCD, 32'h300);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_count", 32'(vif.o_Count), 32'd0);
        check("arst_readyf", 32'(vif.o_ReadyF), 32'd1);
        check("arst_validd", 32'(vif.o_ValidD), 32'd0);
        check("arst_instrd", vif.o_InstrD, 32'h00000013);
        check("arst_pcd", vif.o_PCD, 32'd0);
        check("arst_pc4d", vif.o_PCPlus4D, 32'd0);
        tick();
        rst          = 1'b0;
        vif.i_StallD = 1'b0;
        present(mk_instr(32'h40), 32'h40, 1'b1);
        tick();
        idle();
`ifndef FDQ_BYPASS_EN
        check("postrst_wait_validd", 32'(vif.o_ValidD), 32'd0);
        tick();
`endif
        check("postrst_validd", 32'(vif.o_ValidD), 32'd1);
        check("postrst_pcd", vif.o_PCD, 32'h40);
        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
